// File: rtl/f1_light_seq_if.sv
// Lamp-sequencer bus: start/tick/button inputs and lamp, enable and timing results.
// master drives the stimulus side; slave is the sequencer itself.
interface f1_light_seq_if #(
   parameter int RT_WIDTH = 16
);
   logic                trigger;
   logic                tick;
   logic                react;
   logic                tick_en;
   logic [7:0]          lights;
   logic                rt_valid;
   logic [RT_WIDTH-1:0] reaction_time;
   logic                false_start;

   modport master (
      output trigger, tick, react,
      input  tick_en, lights, rt_valid, reaction_time, false_start
   );

   modport slave (
      input  trigger, tick, react,
      output tick_en, lights, rt_valid, reaction_time, false_start
   );
endinterface

// File: rtl/f1_light_seq.sv
// F1 starting-lights sequencer: lights eight lamps one per tick, holds for an
// LFSR-chosen number of ticks, then times the driver's reaction in clock cycles.
module f1_light_seq #(
   parameter int         RT_WIDTH = 16,
   parameter logic [6:0] SEED     = 7'h5A
) (
   input  logic          clk,
   input  logic          rst,
   f1_light_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEQ  = 2'd1,
      HOLD = 2'd2,
      GO   = 2'd3
   } state_t;

   localparam logic [RT_WIDTH-1:0] RT_ONE = {{(RT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [RT_WIDTH-1:0] RT_MAX = {RT_WIDTH{1'b1}};

   state_t              state_reg, state_next;
   logic [7:0]          lights_reg, lights_next;
   logic [6:0]          hold_cnt_reg, hold_cnt_next;
   logic [RT_WIDTH-1:0] react_cnt_reg, react_cnt_next;
   logic [RT_WIDTH-1:0] reaction_time_reg, reaction_time_next;
   logic                rt_valid_reg, rt_valid_next;
   logic                false_start_reg, false_start_next;
   logic [6:0]          lfsr_reg, lfsr_next;

   // x^7 + x^6 + 1; free-running in every state so the hold length depends
   // on when the driver pressed trigger.
   assign lfsr_next = {lfsr_reg[5:0], lfsr_reg[6] ^ lfsr_reg[5]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg         <= IDLE;
         lights_reg        <= 8'h00;
         hold_cnt_reg      <= 7'd0;
         react_cnt_reg     <= '0;
         reaction_time_reg <= '0;
         rt_valid_reg      <= 1'b0;
         false_start_reg   <= 1'b0;
         lfsr_reg          <= SEED;
      end else begin
         state_reg         <= state_next;
         lights_reg        <= lights_next;
         hold_cnt_reg      <= hold_cnt_next;
         react_cnt_reg     <= react_cnt_next;
         reaction_time_reg <= reaction_time_next;
         rt_valid_reg      <= rt_valid_next;
         false_start_reg   <= false_start_next;
         lfsr_reg          <= lfsr_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      lights_next        = lights_reg;
      hold_cnt_next      = hold_cnt_reg;
      react_cnt_next     = react_cnt_reg;
      reaction_time_next = reaction_time_reg;
      rt_valid_next      = 1'b0;
      false_start_next   = 1'b0;

      unique case (state_reg)
         IDLE: begin
            lights_next = 8'h00;
            if (bus.trigger) begin
               state_next  = SEQ;
               lights_next = 8'h01;
            end
         end

         SEQ: begin
            // A button press beats a coincident tick.
            if (bus.react) begin
               false_start_next = 1'b1;
               lights_next      = 8'h00;
               state_next       = IDLE;
            end else if (bus.tick) begin
               if (lights_reg == 8'hFF) begin
                  state_next    = HOLD;
                  hold_cnt_next = (lfsr_reg == 7'd0) ? 7'd1 : lfsr_reg;
               end else begin
                  lights_next = {lights_reg[6:0], 1'b1};
               end
            end
         end

         HOLD: begin
            if (bus.react) begin
               false_start_next = 1'b1;
               lights_next      = 8'h00;
               state_next       = IDLE;
            end else if (bus.tick) begin
               if (hold_cnt_reg > 7'd1) begin
                  hold_cnt_next = hold_cnt_reg - 7'd1;
               end else begin
                  lights_next    = 8'h00;
                  react_cnt_next = '0;
                  state_next     = GO;
               end
            end
         end

         GO: begin
            lights_next = 8'h00;
            if (bus.react) begin
               reaction_time_next = react_cnt_reg;
               rt_valid_next      = 1'b1;
               state_next         = IDLE;
            end else if (react_cnt_reg != RT_MAX) begin
               react_cnt_next = react_cnt_reg + RT_ONE;
            end
         end

         default: begin
            state_next  = IDLE;
            lights_next = 8'h00;
         end
      endcase
   end

   assign bus.tick_en       = (state_reg == SEQ) || (state_reg == HOLD);
   assign bus.lights        = lights_reg;
   assign bus.rt_valid      = rt_valid_reg;
   assign bus.reaction_time = reaction_time_reg;
   assign bus.false_start   = false_start_reg;

endmodule

// File: tb/tb_f1_light_seq.sv
// Directed bench for f1_light_seq: lamp ramp, LFSR-timed hold, reaction
// timing, false start and mid-sequence reset.
module tb_f1_light_seq;
   localparam int         RT_WIDTH = 16;
   localparam logic [6:0] SEED     = 7'h5A;

   logic clk = 1'b0;
   logic rst;
   int   tests  = 0;
   int   failed = 0;
   int   exp_hold;
   logic [6:0] m_lfsr;
   logic [7:0] ramp [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

   f1_light_seq_if #(.RT_WIDTH(RT_WIDTH)) bus ();

   f1_light_seq #(.RT_WIDTH(RT_WIDTH), .SEED(SEED)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference LFSR, used to predict the hold length at the FF+tick edge.
   always @(posedge clk) begin
      if (!rst) m_lfsr <= SEED;
      else      m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Three idle cycles then a one-cycle tick; returns just after the tick edge.
   task automatic give_tick();
      repeat (3) step();
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b0;
      bus.trigger = 1'b0;
      bus.tick    = 1'b0;
      bus.react   = 1'b0;

      // Reset, then idle.
      step();
      step();
      check("rst_lights", bus.lights, 8'h00);
      check("rst_tick_en", bus.tick_en, 1'b0);
      check("rst_rt_valid", bus.rt_valid, 1'b0);
      check("rst_false_start", bus.false_start, 1'b0);
      check("rst_rt", bus.reaction_time, 16'd0);
      rst = 1'b1;
      repeat (20) step();
      check("idle_lights", bus.lights, 8'h00);
      check("idle_tick_en", bus.tick_en, 1'b0);
      check("idle_rt_valid", bus.rt_valid, 1'b0);
      check("idle_false_start", bus.false_start, 1'b0);
      check("idle_rt", bus.reaction_time, 16'd0);
      $display("[TB] txn reset/idle done");

      // Lamp ramp.
      bus.trigger = 1'b1;
      step();
      bus.trigger = 1'b0;
      check("seq_start", bus.lights, ramp[0]);
      check("seq_tick_en", bus.tick_en, 1'b1);
      for (int i = 1; i < 8; i++) begin
         repeat (3) step();
         check("seq_between", bus.lights, ramp[i-1]);
         bus.tick = 1'b1;
         step();
         bus.tick = 1'b0;
         check("seq_step", bus.lights, ramp[i]);
      end
      $display("[TB] txn ramp reached %0h", bus.lights);

      // FF + tick enters HOLD with hold_cnt from the current LFSR value.
      repeat (3) step();
      bus.tick = 1'b1;
      exp_hold = (m_lfsr == 7'd0) ? 1 : int'(m_lfsr);
      step();
      bus.tick = 1'b0;
      check("hold_entry_lights", bus.lights, 8'hFF);
      check("hold_entry_tick_en", bus.tick_en, 1'b1);
      $display("[TB] txn hold length %0d ticks", exp_hold);
      for (int n = 1; n <= exp_hold; n++) begin
         give_tick();
         if (n < exp_hold) begin
            check("hold_on", bus.lights, 8'hFF);
         end else begin
            check("hold_out_lights", bus.lights, 8'h00);
            check("hold_out_tick_en", bus.tick_en, 1'b0);
         end
      end

      // React on the 6th GO cycle: five counted cycles before it.
      repeat (5) step();
      check("go_no_valid", bus.rt_valid, 1'b0);
      bus.react = 1'b1;
      step();
      bus.react = 1'b0;
      check("rt_valid", bus.rt_valid, 1'b1);
      check("rt_value", bus.reaction_time, 16'd5);
      check("rt_lights", bus.lights, 8'h00);
      step();
      check("rt_valid_pulse", bus.rt_valid, 1'b0);
      check("rt_hold", bus.reaction_time, 16'd5);
      check("rt_idle_tick_en", bus.tick_en, 1'b0);
      $display("[TB] txn reaction time %0d", bus.reaction_time);

      // Trigger with react in IDLE: react ignored, sequence starts.
      bus.trigger = 1'b1;
      bus.react   = 1'b1;
      step();
      bus.trigger = 1'b0;
      bus.react   = 1'b0;
      check("idle_react_lights", bus.lights, 8'h01);
      check("idle_react_no_fs", bus.false_start, 1'b0);
      for (int i = 1; i < 4; i++) begin
         give_tick();
         check("fs_ramp", bus.lights, ramp[i]);
      end

      // False start coincident with tick at 0F.
      repeat (3) step();
      bus.tick  = 1'b1;
      bus.react = 1'b1;
      step();
      bus.tick  = 1'b0;
      bus.react = 1'b0;
      check("fs_pulse", bus.false_start, 1'b1);
      check("fs_lights", bus.lights, 8'h00);
      check("fs_tick_en", bus.tick_en, 1'b0);
      check("fs_rt_kept", bus.reaction_time, 16'd5);
      check("fs_no_valid", bus.rt_valid, 1'b0);
      step();
      check("fs_pulse_end", bus.false_start, 1'b0);
      bus.trigger = 1'b1;
      step();
      bus.trigger = 1'b0;
      check("fs_restart", bus.lights, 8'h01);
      $display("[TB] txn false start and restart");

      // Reset during HOLD.
      for (int i = 1; i < 8; i++) give_tick();
      give_tick();
      check("mid_hold_lights", bus.lights, 8'hFF);
      check("mid_hold_tick_en", bus.tick_en, 1'b1);
      step();
      rst         = 1'b0;
      bus.trigger = 1'b1;
      step();
      check("mid_rst_lights", bus.lights, 8'h00);
      check("mid_rst_tick_en", bus.tick_en, 1'b0);
      check("mid_rst_rt", bus.reaction_time, 16'd0);
      check("mid_rst_lfsr", dut.lfsr_reg, SEED);
      step();
      check("rst_trig_lights", bus.lights, 8'h00);
      check("rst_trig_tick_en", bus.tick_en, 1'b0);
      rst         = 1'b1;
      bus.trigger = 1'b0;
      step();
      check("post_rst_lights", bus.lights, 8'h00);
      check("post_rst_tick_en", bus.tick_en, 1'b0);
      $display("[TB] txn reset mid-hold");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/f1_light_seq.md
Name: f1_light_seq

Overview:
Downstream consumer of the clock-tick divider in the F1 starting-lights design. On a trigger, it lights eight lamps one per tick. It then holds all lamps on for a pseudo-random number of ticks, turns them off, and measures the driver's reaction time in clock cycles. It drives the divider's enable and flags false starts.

Parameters:
RT_WIDTH, 16, width of the reaction-time counter and result.
SEED, 7'h5A, non-zero reset value of the 7-bit LFSR.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-low reset; sampled on posedge clk; rst=0 resets the block.
trigger  input  1  start request; honoured only in IDLE.
tick  input  1  one-cycle pulse from the upstream tick divider.
react  input  1  driver button, already synchronised and debounced.
tick_en  output  1  enable for the upstream divider; combinational, 1 in SEQ and HOLD.
lights  output  8  lamp drive, registered.
rt_valid  output  1  one-cycle pulse when reaction_time is updated.
reaction_time  output  RT_WIDTH  last measured reaction time in cycles; holds until next measurement.
false_start  output  1  one-cycle pulse on react before lights go out.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, lights=0, hold_cnt=0, react_cnt=0.
  - reaction_time=0, rt_valid=0, false_start=0.
  - lfsr=SEED.
  - Reset mid-sequence aborts immediately; lights=0 on the next cycle.
- LFSR:
  - 7-bit, advances every cycle out of reset, in all states.
  - next = {lfsr[5:0], lfsr[6]^lfsr[5]} (x^7+x^6+1, maximal length 127).
  - Never reaches zero.
- rt_valid and false_start default to 0 each cycle; they are asserted only as stated below.
- IDLE:
  - lights=0.
  - trigger=1 -> SEQ, with lights<=8'h01 on the same edge.
  - react is ignored in IDLE, including when it coincides with trigger.
- SEQ:
  - On tick=1: lights <= {lights[6:0],1'b1}.
  - When lights==8'hFF and tick=1: go to HOLD; lights stay 8'hFF.
  - On that same edge, load hold_cnt <= (lfsr==0) ? 1 : lfsr, using the current lfsr value (range 1..127).
- HOLD:
  - On tick=1 with hold_cnt>1: hold_cnt decrements.
  - On tick=1 with hold_cnt==1: lights<=0, react_cnt<=0, go to GO.
- GO:
  - tick_en=0; lights=0.
  - On react=0: react_cnt increments each cycle, saturating at all-ones (no wrap).
  - On react=1: reaction_time<=react_cnt, rt_valid<=1, go to IDLE.
  - react in the first GO cycle yields 0.
- False start:
  - react=1 in SEQ or HOLD: false_start<=1, lights<=0, go to IDLE; reaction_time is unchanged.
  - False start takes priority over a simultaneous tick.
- trigger is ignored in SEQ, HOLD and GO.
- tick is ignored in IDLE and GO.
- Latency:
  - Lamp update is 1 cycle after the tick edge.
  - rt_valid is registered, 1 cycle after react is sampled.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release with no trigger for 20 cycles -> lights=0, tick_en=0, rt_valid=0, false_start=0, reaction_time=0.
- Sequence: trigger pulse, then tick every 4 cycles -> lights go 01,03,07,0F,1F,3F,7F,FF, one step per tick; tick_en=1 from the cycle after trigger.
- Hold length: SEED=7'h5A, with a bench LFSR model sampled at the FF+tick edge -> lights go 0 exactly on the hold_cnt-th tick in HOLD; tick_en drops in the same cycle.
- Reaction: react asserted on the 6th GO cycle -> rt_valid pulse for 1 cycle with reaction_time=5; state returns to IDLE.
- False start: react=1 coincident with the tick at lights=8'h0F -> false_start pulse, lights=0 next cycle, reaction_time unchanged; a new trigger restarts at 8'h01.
- Reset mid-operation: rst=0 during HOLD -> lights=0 and tick_en=0 next cycle; lfsr=SEED; trigger ignored while rst=0.
